// File: rtl/rv_sink_checker.sv
// rv_sink_checker -- ready/valid sink that checks an incrementing data stream.
//
// The sink throttles its ready with a Galois LFSR, counts accepted beats and
// checks that the accepted data follows 0,1,2,... modulo 2^WIDTH. It also
// checks that the source holds valid and data stable while a beat is stalled.
// The first error of either kind captures the offending data and the value
// the sink expected at that beat.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   in_data     data beat from the pipeline under test
//   in_valid    source has a beat on in_data
//   in_ready    sink accepts the beat this cycle (combinational)
//   ready_mode  00 always, 01 LFSR 50%, 10 LFSR 25%, 11 never ready
//   xfer_count  completed transfers, saturating
//   err_seq     sticky: accepted beat did not match the expected sequence
//   err_proto   sticky: source dropped or changed a stalled beat
//   err_data    in_data of the first failing beat
//   err_expect  expected value at the first failing beat
//   state       00 IDLE, 01 RUN, 10 FAIL, 11 DONE
module rv_sink_checker #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [31:0] MAX_COUNT = 32'hFFFF_FFFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ready_mode,
    output logic [31:0]      xfer_count,
    output logic             err_seq,
    output logic             err_proto,
    output logic [WIDTH-1:0] err_data,
    output logic [WIDTH-1:0] err_expect,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FAIL = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             err_seq_q, err_seq_d;
    logic             err_proto_q, err_proto_d;
    logic [WIDTH-1:0] err_data_q, err_data_d;
    logic [WIDTH-1:0] err_exp_q, err_exp_d;
    // Stall history: a beat was presented but not accepted last cycle.
    logic             hold_q, hold_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;

    logic armed, mode_ready, fire, seq_bad, proto_bad;

    always_comb begin
        armed = (state_q == S_RUN) || (state_q == S_FAIL);

        unique case (ready_mode)
            2'b00:   mode_ready = 1'b1;
            2'b01:   mode_ready = lfsr_q[0];
            2'b10:   mode_ready = (lfsr_q[1:0] == 2'b00);
            default: mode_ready = 1'b0;
        endcase

        // Gated by reset so the sink never accepts while reset is held,
        // even before the first reset edge has settled the state register.
        in_ready = !reset && armed && mode_ready;
        fire     = in_valid && in_ready;

        seq_bad   = fire && (in_data != exp_q);
        proto_bad = armed && hold_q && (!in_valid || (in_data != hold_data_q));

        // Galois right shift: feed the output bit back through the taps.
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        // Resync to the received beat so a single bad beat is one error.
        exp_d = fire ? (in_data + ONE) : exp_q;
        cnt_d = (fire && (cnt_q != 32'hFFFF_FFFF)) ? (cnt_q + 32'd1) : cnt_q;

        err_seq_d   = err_seq_q;
        err_proto_d = err_proto_q;
        err_data_d  = err_data_q;
        err_exp_d   = err_exp_q;
        if (state_q != S_DONE && (seq_bad || proto_bad)) begin
            if (!err_seq_q && !err_proto_q) begin
                err_data_d = in_data;
                err_exp_d  = exp_q;
            end
            err_seq_d   = err_seq_q   || seq_bad;
            err_proto_d = err_proto_q || proto_bad;
        end

        hold_d      = armed && in_valid && !in_ready;
        hold_data_d = in_data;

        // Reaching the count wins over a simultaneous error.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN, S_FAIL: begin
                if (fire && (cnt_d == MAX_COUNT))
                    state_d = S_DONE;
                else if (state_q == S_RUN && (err_seq_d || err_proto_d))
                    state_d = S_FAIL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            exp_q       <= '0;
            cnt_q       <= '0;
            err_seq_q   <= 1'b0;
            err_proto_q <= 1'b0;
            err_data_q  <= '0;
            err_exp_q   <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            err_seq_q   <= err_seq_d;
            err_proto_q <= err_proto_d;
            err_data_q  <= err_data_d;
            err_exp_q   <= err_exp_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign xfer_count = cnt_q;
    assign err_seq    = err_seq_q;
    assign err_proto  = err_proto_q;
    assign err_data   = err_data_q;
    assign err_expect = err_exp_q;
    assign state      = state_q;

endmodule

// File: doc/rv_sink_checker.md
RV_SINK_CHECKER -- requirements
Module: rv_sink_checker

Interface
- REQ-001: Parameter WIDTH, default 16, data width of the checked stream.
- REQ-002: Parameter SEED, default 16'hACE1, nonzero reset value of the ready LFSR.
- REQ-003: Parameter MAX_COUNT, default 32'hFFFF_FFFF, transfer count at which the block enters DONE.
- REQ-004: clock  input  1  sole clock; all state updates on the rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: in_data  input  WIDTH  downstream data from the pipeline under test.
- REQ-007: in_valid  input  1  upstream asserts that in_data is valid.
- REQ-008: in_ready  output  1  sink accepts the beat this cycle.
- REQ-009: ready_mode  input  2  00 always ready, 01 LFSR 50% ready, 10 LFSR 25% ready, 11 never ready.
- REQ-010: xfer_count  output  32  number of completed transfers.
- REQ-011: err_seq  output  1  sticky; a beat did not match the expected sequence.
- REQ-012: err_proto  output  1  sticky; a ready/valid rule was violated.
- REQ-013: err_data  output  WIDTH  in_data of the first failing beat.
- REQ-014: err_expect  output  WIDTH  expected value at the first failing beat.
- REQ-015: state  output  2  00 IDLE, 01 RUN, 10 FAIL, 11 DONE.

Function
- REQ-016: A transfer (fire) SHALL occur exactly when in_valid && in_ready at a rising edge.
- REQ-017: The LFSR SHALL be a 16-bit Galois LFSR, taps 16'hB400, shifting right every cycle in every state.
- REQ-018: in_ready SHALL be combinational from the registered LFSR and ready_mode: 01 -> lfsr[0]; 10 -> lfsr[1:0]==2'b00.
- REQ-019: in_ready SHALL be 0 in IDLE and in DONE, regardless of ready_mode.
- REQ-020: in_ready SHALL follow ready_mode in RUN and FAIL; in FAIL the sink keeps draining.
- REQ-021: The expected value SHALL start at 0 and increment by 1, modulo 2^WIDTH, on every fire.
- REQ-022: At wrap-around, 'hFFFF is followed by an expected value of 0 with no error.
- REQ-023: On a fire with in_data != expected, the block SHALL set err_seq and latch err_data/err_expect.
- REQ-024: err_data/err_expect SHALL be latched only for the first error of either kind.
- REQ-025: The expected value SHALL still advance to in_data+1 after a mismatch, so that one bad beat produces one error.
- REQ-026: Protocol rule: if in_valid=1 and in_ready=0 on cycle N, then on cycle N+1 in_valid SHALL be 1 and in_data SHALL equal its cycle-N value.
- REQ-027: Any violation of the REQ-026 rule SHALL set err_proto.
- REQ-028: The REQ-026 check SHALL be armed only in RUN and FAIL.
- REQ-029: xfer_count SHALL increment by 1 on every fire, saturating at 32'hFFFF_FFFF.
- REQ-030: IDLE -> RUN one cycle after reset deasserts (IDLE lasts exactly one cycle).
- REQ-031: RUN -> FAIL on the cycle either sticky error sets; FAIL is terminal until reset.
- REQ-032: RUN or FAIL -> DONE when xfer_count reaches MAX_COUNT.
- REQ-033: DONE SHALL keep err_* frozen.
- REQ-034: When an error and MAX_COUNT are reached in the same cycle, the error is recorded and the state goes to DONE.
- REQ-035: A ready_mode change SHALL take effect on the same cycle; the LFSR is not reset by it.
- REQ-036: Latency: an error flag and its captured data SHALL be visible on the cycle after the offending edge.

Reset
- REQ-037: While reset=1: state=IDLE, lfsr=SEED, expected=0, xfer_count=0, err_seq=0, err_proto=0, err_data=0, err_expect=0, in_ready=0.
- REQ-038: Reset asserted mid-stream SHALL discard any in-flight beat and clear all counters and errors on the next edge.
- REQ-039: The protocol-check history SHALL be cleared by reset, so that no err_proto is raised on the first post-reset cycle.

Verification
- REQ-040: mode 00, source sends 0..9 back-to-back -> xfer_count=10, no errors, state=RUN.
- REQ-041: mode 01, source sends 0..299 with random valid -> xfer_count=300, err_seq=0, err_proto=0.
- REQ-042: mode 00, source sends 0,1,2,5,6 -> err_seq=1, err_data=5, err_expect=3, state=FAIL, xfer_count=5.
- REQ-043: mode 11, valid=1 with data 0 for 1 cycle, then data 7 -> err_proto=1, err_data=7, err_expect=0, in_ready stays 0.
- REQ-044: MAX_COUNT=4, mode 00, sends 0..9 -> state=DONE after 4 fires, in_ready=0, xfer_count=4.
- REQ-045: WIDTH=4, mode 00, sends 0..15,0,1 -> no err_seq, xfer_count=18; then reset mid-run -> all outputs at reset values, next expected=0.
